slow_clk_monitor: RTL and testbench



---
 rtl/slow_clk_monitor_if.sv | 37 +++
 rtl/slow_clk_monitor.sv | 167 ++++++++++++++++
 tb/tb_slow_clk_monitor.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/slow_clk_monitor_if.sv
// Bundle of signals between a slow divided clock source and its monitor.
// The master side drives slow_clk; the slave (the monitor) reports ticks,
// the measured half-period and the health flags.
interface slow_clk_monitor_if #(
    parameter int CNT_W = 32
);
    logic             slow_clk;
    logic             tick_rise;
    logic             tick_fall;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             freq_ok;
    logic             stalled;
    logic [15:0]      edge_count;

    modport master (
        output slow_clk,
        input  tick_rise,
        input  tick_fall,
        input  half_period,
        input  period_valid,
        input  freq_ok,
        input  stalled,
        input  edge_count
    );

    modport slave (
        input  slow_clk,
        output tick_rise,
        output tick_fall,
        output half_period,
        output period_valid,
        output freq_ok,
        output stalled,
        output edge_count
    );
endinterface

// File: rtl/slow_clk_monitor.sv
// Receive-side monitor for a divided slow clock. Brings slow_clk into the
// clk_in domain, emits one-cycle rise/fall ticks, measures each half-period
// in clk_in cycles and flags off-frequency or stalled clocks.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no edge seen since reset or stall; nothing to measure yet
// ST_ARMED  | one edge seen; the next edge gives the first measurement
// ST_LOCKED | measuring continuously, every edge updates half_period
module slow_clk_monitor #(
    parameter int EXPECTED_HALF = 25000,
    parameter int TOLERANCE     = 16,
    parameter int TIMEOUT       = 100000,
    parameter int CNT_W         = 32
) (
    input  logic                  clk_in,
    input  logic                  rst,
    slow_clk_monitor_if.slave     bus
);

    // Tolerance window evaluated one bit wider so cnt+1 can never wrap.
    localparam logic [CNT_W:0] C_HI = (CNT_W+1)'(EXPECTED_HALF + TOLERANCE);
    localparam logic [CNT_W:0] C_LO = (TOLERANCE > EXPECTED_HALF) ? '0
                                    : (CNT_W+1)'(EXPECTED_HALF - TOLERANCE);
    localparam logic [CNT_W-1:0] C_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_s1;
    logic             r_s2;
    logic             r_prev;
    logic [CNT_W-1:0] r_cnt;

    logic             r_tick_rise;
    logic             r_tick_fall;
    logic [CNT_W-1:0] r_half_period;
    logic             r_period_valid;
    logic             r_freq_ok;
    logic             r_stalled;
    logic [15:0]      r_edge_count;

    logic             w_edge;
    logic             w_timeout;
    logic             w_capture;
    logic [CNT_W:0]   w_meas;
    logic [CNT_W-1:0] w_meas_sat;
    logic             w_in_tol;

    assign w_edge     = r_s2 ^ r_prev;
    // An edge in the same cycle as the terminal count takes priority.
    assign w_timeout  = (r_cnt == C_TIMEOUT_M1) && !w_edge;
    assign w_meas     = {1'b0, r_cnt} + 1'b1;
    assign w_meas_sat = (&r_cnt) ? r_cnt : (r_cnt + 1'b1);
    assign w_in_tol   = (w_meas >= C_LO) && (w_meas <= C_HI);

    // Two-flop synchronizer followed by the edge-history flop.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= bus.slow_clk;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Cycles since the last detected edge; saturates instead of wrapping.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= '0;
        end else if (!(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and measurement strobe.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_edge) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_LOCKED;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_edge) begin
                    w_capture = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Registered ticks, measurement, health flags and edge counter.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_tick_rise    <= 1'b0;
            r_tick_fall    <= 1'b0;
            r_half_period  <= '0;
            r_period_valid <= 1'b0;
            r_freq_ok      <= 1'b0;
            r_stalled      <= 1'b0;
            r_edge_count   <= '0;
        end else begin
            r_tick_rise <= w_edge & r_s2;
            r_tick_fall <= w_edge & ~r_s2;
            if (w_edge) begin
                r_edge_count <= r_edge_count + 1'b1;
            end
            if (w_capture) begin
                r_half_period  <= w_meas_sat;
                r_period_valid <= 1'b1;
                r_freq_ok      <= w_in_tol;
            end else if (w_timeout) begin
                r_period_valid <= 1'b0;
                r_freq_ok      <= 1'b0;
            end
            if (w_edge) begin
                r_stalled <= 1'b0;
            end else if (w_timeout) begin
                r_stalled <= 1'b1;
            end
        end
    end

    assign bus.tick_rise    = r_tick_rise;
    assign bus.tick_fall    = r_tick_fall;
    assign bus.half_period  = r_half_period;
    assign bus.period_valid = r_period_valid;
    assign bus.freq_ok      = r_freq_ok;
    assign bus.stalled      = r_stalled;
    assign bus.edge_count   = r_edge_count;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Self-checking bench for slow_clk_monitor with a time-based reference model.
module tb_slow_clk_monitor;

    localparam int EXP = 10;
    localparam int TOL = 1;
    localparam int TMO = 40;

    logic clk_in = 1'b0;
    logic rst;

    always #5 clk_in = ~clk_in;

    slow_clk_monitor_if #(.CNT_W(32)) bus();

    slow_clk_monitor #(
        .EXPECTED_HALF(EXP),
        .TOLERANCE    (TOL),
        .TIMEOUT      (TMO),
        .CNT_W        (32)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: slow_clk samples indexed by clk_in edge number since
    // reset; an edge is reported two samples after it is first seen.
    logic        m_hist[$];
    int          m_n;
    int          m_last;
    int          m_run;
    int          m_half;
    logic [15:0] m_edges;
    logic        m_rise, m_fall, m_valid, m_fok, m_stalled;
    bit          cmp_en = 1'b1;
    logic        lvl;

    typedef struct {
        int iv;
        int n_tog;
        int half;
        bit fok;
    } row_t;
    row_t rows[6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        repeat (3) m_hist.push_back(1'b0);
        m_n = 0; m_last = 0; m_run = 0; m_half = 0; m_edges = '0;
        m_rise = 0; m_fall = 0; m_valid = 0; m_fok = 0; m_stalled = 0;
    endtask

    task automatic model_update(input logic v);
        logic ev;
        if (rst) begin
            model_reset();
            return;
        end
        m_hist.push_back(v);
        m_n++;
        ev = (m_hist[1] != m_hist[0]);
        m_rise = ev && m_hist[1];
        m_fall = ev && !m_hist[1];
        if (ev) begin
            m_edges++;
            if (m_run > 0) begin
                m_half  = m_n - m_last;
                m_valid = 1'b1;
                m_fok   = (m_half >= EXP - TOL) && (m_half <= EXP + TOL);
            end
            m_run++;
            m_stalled = 1'b0;
            m_last    = m_n;
        end else if (m_n - m_last == TMO) begin
            m_stalled = 1'b1;
            m_valid   = 1'b0;
            m_fok     = 1'b0;
            m_run     = 0;
        end
        void'(m_hist.pop_front());
    endtask

    task automatic compare_model();
        chk("tick_rise",    bus.tick_rise,    m_rise);
        chk("tick_fall",    bus.tick_fall,    m_fall);
        chk("half_period",  bus.half_period,  m_half);
        chk("period_valid", bus.period_valid, m_valid);
        chk("freq_ok",      bus.freq_ok,      m_fok);
        chk("stalled",      bus.stalled,      m_stalled);
        chk("edge_count",   bus.edge_count,   m_edges);
    endtask

    task automatic step(input logic v);
        bus.slow_clk = v;
        @(posedge clk_in);
        model_update(v);
        @(negedge clk_in);
        if (cmp_en) compare_model();
    endtask

    task automatic hold(input logic v, input int iv);
        repeat (iv) step(v);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step(bus.slow_clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] prev_cnt;
        bit saw_wrap;
        int sel, iv;

        rows[0] = '{iv: 10, n_tog: 3, half: 10, fok: 1'b1};
        rows[1] = '{iv: 11, n_tog: 3, half: 11, fok: 1'b1};
        rows[2] = '{iv: 12, n_tog: 3, half: 12, fok: 1'b0};
        rows[3] = '{iv:  9, n_tog: 3, half:  9, fok: 1'b1};
        rows[4] = '{iv: 40, n_tog: 3, half: 40, fok: 1'b0};
        rows[5] = '{iv:  9, n_tog: 2, half:  9, fok: 1'b1};

        rst = 1'b1;
        bus.slow_clk = 1'b0;
        lvl = 1'b0;
        model_reset();
        @(negedge clk_in);
        do_reset(2);
        compare_model();

        // Constant slow_clk from reset: stall after TIMEOUT cycles, no edges.
        hold(1'b0, 39);
        chk("t4_no_stall_39", bus.stalled, 0);
        step(1'b0);
        chk("t4_stall_40", bus.stalled, 1);
        chk("t4_edge_count", bus.edge_count, 0);
        hold(1'b0, 5);
        chk("t4_tick_rise", bus.tick_rise, 0);
        chk("t4_edge_count_late", bus.edge_count, 0);
        do_reset(2);

        // First-edge latency: tick three edges after the first high sample.
        lvl = 1'b1;
        step(lvl); chk("t1_lat_c1", bus.tick_rise, 0);
        step(lvl); chk("t1_lat_c2", bus.tick_rise, 0);
        step(lvl); chk("t1_lat_c3", bus.tick_rise, 1);
        chk("t1_first_count", bus.edge_count, 1);
        step(lvl); chk("t1_lat_c4", bus.tick_rise, 0);
        hold(lvl, 6);

        // Interval table, including an edge exactly at the terminal count.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < rows[r].n_tog; k++) begin
                lvl = ~lvl;
                hold(lvl, rows[r].iv);
            end
            chk($sformatf("row%0d_half", r),  bus.half_period,  rows[r].half);
            chk($sformatf("row%0d_fok", r),   bus.freq_ok,      rows[r].fok);
            chk($sformatf("row%0d_valid", r), bus.period_valid, 1);
            chk($sformatf("row%0d_stall", r), bus.stalled,      0);
        end

        // Stall while locked, then resume.
        lvl = ~lvl;
        hold(lvl, 3);
        chk("t3_edge_tick", bus.tick_rise | bus.tick_fall, 1);
        hold(lvl, 39);
        chk("t3_no_stall_39", bus.stalled, 0);
        step(lvl);
        chk("t3_stall", bus.stalled, 1);
        chk("t3_valid", bus.period_valid, 0);
        chk("t3_fok", bus.freq_ok, 0);
        chk("t3_half_kept", bus.half_period, 9);
        lvl = ~lvl; hold(lvl, 10);
        chk("t3_resume_stall", bus.stalled, 0);
        chk("t3_resume_valid1", bus.period_valid, 0);
        lvl = ~lvl; hold(lvl, 10);
        chk("t3_resume_valid2", bus.period_valid, 1);
        chk("t3_resume_half", bus.half_period, 10);

        // Asynchronous reset between edges while locked.
        if (lvl) begin lvl = 1'b0; hold(lvl, 10); end
        lvl = 1'b1; hold(lvl, 10);
        lvl = 1'b0; hold(lvl, 5);
        rst = 1'b1;
        #1;
        chk("t5_rst_rise",  bus.tick_rise, 0);
        chk("t5_rst_fall",  bus.tick_fall, 0);
        chk("t5_rst_half",  bus.half_period, 0);
        chk("t5_rst_valid", bus.period_valid, 0);
        chk("t5_rst_fok",   bus.freq_ok, 0);
        chk("t5_rst_stall", bus.stalled, 0);
        chk("t5_rst_count", bus.edge_count, 0);
        repeat (2) step(lvl);
        rst = 1'b0;
        hold(lvl, 10);
        chk("t5_valid_0edge", bus.period_valid, 0);
        lvl = 1'b1; hold(lvl, 10);
        chk("t5_valid_1edge", bus.period_valid, 0);
        chk("t5_count_1edge", bus.edge_count, 1);
        lvl = 1'b0; hold(lvl, 10);
        chk("t5_valid_2edge", bus.period_valid, 1);
        chk("t5_half_2edge", bus.half_period, 10);

        // Randomised intervals against the model.
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      iv = $urandom_range(8, 12);
            else if (sel < 85) iv = $urandom_range(38, 42);
            else if (sel < 95) iv = $urandom_range(1, 3);
            else               iv = 50;
            lvl = ~lvl;
            hold(lvl, iv);
        end

        // edge_count wrap: toggle every cycle up to near the top, then cross.
        cmp_en = 1'b0;
        while (m_edges < 16'hFFF0) begin
            lvl = ~lvl;
            step(lvl);
        end
        cmp_en = 1'b1;
        saw_wrap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            prev_cnt = bus.edge_count;
            lvl = ~lvl;
            step(lvl);
            if (prev_cnt == 16'hFFFF) begin
                chk("t6_wrap_zero", bus.edge_count, 0);
                saw_wrap = 1'b1;
            end
        end
        chk("t6_wrap_seen", saw_wrap, 1);

        // Edge arriving exactly at the terminal count: no stall.
        lvl = ~lvl; hold(lvl, 40);
        lvl = ~lvl; hold(lvl, 40);
        lvl = ~lvl; hold(lvl, 3);
        chk("t6_coincide_stall", bus.stalled, 0);
        chk("t6_coincide_half", bus.half_period, 40);
        chk("t6_coincide_valid", bus.period_valid, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
